rs_pipe_addsub: RTL and testbench
=================================

// Module: rs_pipe_addsub
// PURPOSE
//  Pipelined, parametrised add/subtract unit for operands wider than one hard carry chain.
//  - Splits WIDTH into NSEG = ceil(WIDTH/SEG_WIDTH) segments; segment k resolves in pipe stage k.
//  - Carry is registered between segments; operand/result bits are skew-aligned.
//  - Valid/ready streaming interface. Used by DSP-side datapaths and as a wide-$alu fallback.
// PARAMETERS
//  WIDTH      64  operand/result width, >= 2
//  SEG_WIDTH  32  bits per carry-chain segment; 3..`MAX_CARRY_CHAIN, elaboration error otherwise
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: B inverted (BB = ~b)
//  ci         in   1      carry in (sub=1, ci=1 gives a-b)
//  sat        in   1      saturate request (ignored unless RS_ADDSUB_SAT_EN)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  a + BB + ci, modulo 2^WIDTH
//  co         out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: a[MSB]==BB[MSB] && y[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset: out_valid=0, y=0, co=0, ovf=0; all stage-valid flags and carry regs 0; in-flight beats discarded.
//  - adv = ~out_valid | out_ready; in_ready = adv. The whole pipe shifts only when adv=1.
//  - Beat accepted when in_valid & in_ready; appears on outputs exactly NSEG cycles later if adv stays 1.
//  - Stage k (0..NSEG-1): adds segment k of a/BB with carry from stage k-1 (stage 0: ci); stores sum
//    bits and carry-out; higher segments' operands ride skew registers; lower sums ride delay registers.
//  - Last segment width = WIDTH - (NSEG-1)*SEG_WIDTH (may be narrower). NSEG=1: single registered stage.
//  - Stall (out_valid & ~out_ready): all stages hold, outputs stable, in_ready=0; no loss, no duplication, order kept.
//  - Bubbles (in_valid=0) propagate as stage-valid=0; they are not collapsed.
//  - Simultaneous accept and output-accept in one cycle is legal at full throughput (1 beat/cycle).
//  - sub, ci, sat are captured with the beat and travel with it.
// CONFIGURATION
//  RS_ADDSUB_SAT_EN defined:
//   - sat travels with the beat. When sat=1 and ovf=1: y = 0x7FF..F if a[MSB]=0, else 0x800..0.
//   - co and ovf still report the unsaturated result. Saturation adds no latency.
//  RS_ADDSUB_SAT_EN undefined:
//   - sat is ignored; y is always the wrapped result; no saturation logic.
// STRUCTURE
//  - Package rs_arith_pkg: function rs_nseg(width,seg); function rs_seg_w(k,width,seg);
//    localparam RS_MAX_CARRY = `MAX_CARRY_CHAIN.
//  - Sub-module rs_carry_seg #(W): combinational W-bit chain of adder_carry cells.
//    Ports: cin, a, bb, sum, cout. One instance per segment via generate.
//  - Top: handshake/advance logic, per-stage valid bits, skew/delay registers, optional saturation.
// TESTING (WIDTH=64, SEG_WIDTH=32 unless noted; latency 2; out_ready=1 unless noted)
//  1. a=0xFFFF_FFFF, b=1, sub=0, ci=0 -> y=0x1_0000_0000, co=0, ovf=0 two cycles after accept
//     (carry crosses segment boundary).
//  2. a=0, b=1, sub=1, ci=1 -> y=0xFFFF_FFFF_FFFF_FFFF, co=0, ovf=0.
//  3. a=0x7FFF_FFFF_FFFF_FFFF, b=1, add:
//     - sat=0 -> y=0x8000_0000_0000_0000, ovf=1, co=0.
//     - sat=1 with RS_ADDSUB_SAT_EN -> y=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
//  4. Stream 6 beats back-to-back; drop out_ready for 3 cycles after the first result:
//     in_ready=0 during the stall, outputs held, all 6 results in order, none repeated.
//  5. Assert rst_n low while 2 beats are in flight -> out_valid=0 immediately;
//     after release, no stale result emerges; next beat's result is correct.
//  6. WIDTH=40, SEG_WIDTH=16 (NSEG=3, last segment 8 bits): a=0xFF_FFFF_FFFF, b=1 -> y=0, co=1, latency 3.

Source files
------------

// File: rtl/rs_arith_pkg.sv
// Shared helpers for the segmented add/subtract pipeline: segment count, per-segment
// width and the longest carry chain a single segment may use (MAX_CARRY_CHAIN).
`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

package rs_arith_pkg;

    localparam int RS_MAX_CARRY = `MAX_CARRY_CHAIN;

    function automatic int rs_nseg(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    // The top segment takes whatever is left over, so it may be narrower.
    function automatic int rs_seg_w(input int k, input int width, input int seg);
        return (k == rs_nseg(width, seg) - 1) ? width - k * seg : seg;
    endfunction

endpackage

// File: rtl/rs_carry_seg.sv
// Combinational W-bit ripple segment built from adder_carry cells; one per pipe stage.
module rs_carry_seg #(
    parameter int W = 32
) (
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] bb,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_adder_carry
        assign sum[i]   = a[i] ^ bb[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & bb[i]) | (w_c[i] & (a[i] ^ bb[i]));
    end

    assign cout = w_c[W];

endmodule

// File: rtl/rs_pipe_addsub.sv
// Pipelined wide add/subtract: one carry-chain segment per stage, valid/ready stream.
// Optional saturation on signed overflow is built only when RS_ADDSUB_SAT_EN is defined.
module rs_pipe_addsub
    import rs_arith_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG = rs_nseg(WIDTH, SEG_WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("rs_pipe_addsub: WIDTH must be at least 2");
    end
    if (SEG_WIDTH < 3 || SEG_WIDTH > RS_MAX_CARRY) begin : g_bad_seg
        $error("rs_pipe_addsub: SEG_WIDTH must lie in 3..MAX_CARRY_CHAIN");
    end

    // r_x[k]: segments 0..k hold sums, higher segments still hold operand A.
    // r_bbs[k]: operand BB shifted down so segment k+1 sits at bit 0.
    logic [NSEG-1:0][WIDTH-1:0] r_x, r_bbs, w_x_nxt, w_bbs_nxt;
    logic [NSEG-1:0]            r_v, r_c, r_sat, w_v_nxt, w_c_nxt, w_sat_nxt;
    logic                       r_ovf, w_ovf_nxt;
    logic                       w_adv;
    logic                       w_unused;

    assign w_adv    = ~r_v[NSEG-1] | out_ready;
    assign w_unused = ^{sat, r_sat[NSEG-1], r_bbs[NSEG-1]};

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_WIDTH;
        localparam int SW = rs_seg_w(k, WIDTH, SEG_WIDTH);

        logic [WIDTH-1:0] w_x_in, w_bbs_in, w_mix;
        logic             w_cin, w_v_in, w_sat_in, w_cout;
        logic [SW-1:0]    w_sum;

        if (k == 0) begin : g_first
            assign w_x_in   = a;
            assign w_bbs_in = sub ? ~b : b;
            assign w_cin    = ci;
            assign w_v_in   = in_valid;
`ifdef RS_ADDSUB_SAT_EN
            assign w_sat_in = sat;
`else
            assign w_sat_in = 1'b0;
`endif
        end else begin : g_next
            assign w_x_in   = r_x[k-1];
            assign w_bbs_in = r_bbs[k-1];
            assign w_cin    = r_c[k-1];
            assign w_v_in   = r_v[k-1];
            assign w_sat_in = r_sat[k-1];
        end

        rs_carry_seg #(.W(SW)) u_seg (
            .cin  (w_cin),
            .a    (w_x_in[LO +: SW]),
            .bb   (w_bbs_in[SW-1:0]),
            .sum  (w_sum),
            .cout (w_cout)
        );

        always_comb begin
            w_mix           = w_x_in;
            w_mix[LO +: SW] = w_sum;
        end

        assign w_bbs_nxt[k] = w_bbs_in >> SW;
        assign w_c_nxt[k]   = w_cout;
        assign w_v_nxt[k]   = w_v_in;
        assign w_sat_nxt[k] = w_sat_in;

        if (k == NSEG - 1) begin : g_last
            // Top bit of w_x_in is still a[MSB]; top bit of the segment sum is y[MSB].
            logic w_a_msb;
            assign w_a_msb   = w_x_in[WIDTH-1];
            assign w_ovf_nxt = (w_a_msb == w_bbs_in[SW-1]) && (w_sum[SW-1] != w_a_msb);
`ifdef RS_ADDSUB_SAT_EN
            assign w_x_nxt[k] = (w_sat_in && w_ovf_nxt) ?
                                {w_a_msb, {(WIDTH-1){~w_a_msb}}} : w_mix;
`else
            assign w_x_nxt[k] = w_mix;
`endif
        end else begin : g_mid
            assign w_x_nxt[k] = w_mix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_bbs <= '0;
            r_v   <= '0;
            r_c   <= '0;
            r_sat <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_x   <= w_x_nxt;
            r_bbs <= w_bbs_nxt;
            r_v   <= w_v_nxt;
            r_c   <= w_c_nxt;
            r_sat <= w_sat_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[NSEG-1];
    assign y         = r_x[NSEG-1];
    assign co        = r_c[NSEG-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_rs_pipe_addsub.sv
// Directed bench for rs_pipe_addsub: 64/32 instance with scoreboard, plus a 40/16 instance.
`timescale 1ns/1ps
module tb_rs_pipe_addsub;

`ifdef RS_ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        ci;
        logic        sat;
        logic [63:0] y;
        logic        co;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [63:0] y;
        logic        co;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, sub, ci, sat, out_valid, out_ready, co, ovf;
    logic [63:0] a, b, y;
    logic        in_valid40, in_ready40, out_valid40, co40, ovf40;
    logic [39:0] a40, b40, y40;

    rs_pipe_addsub #(.WIDTH(64), .SEG_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .ci(ci), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co), .ovf(ovf)
    );

    rs_pipe_addsub #(.WIDTH(40), .SEG_WIDTH(16)) dut40 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid40), .in_ready(in_ready40),
        .a(a40), .b(b40), .sub(1'b0), .ci(1'b0), .sat(1'b0),
        .out_valid(out_valid40), .out_ready(1'b1), .y(y40), .co(co40), .ovf(ovf40)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    vec_t tbl [11];
    exp_t exp_q [$];
    exp_t cur_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    function automatic vec_t mk(input logic [63:0] va, input logic [63:0] vb, input logic vsub,
                                input logic vci, input logic vsat, input logic [63:0] vy,
                                input logic vco, input logic vovf);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vsub; v.ci = vci; v.sat = vsat;
        v.y = vy; v.co = vco; v.ovf = vovf;
        return v;
    endfunction

    // Scoreboard: record accepted beats, compare each consumed result in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got y=%h, required no result", y);
            end else begin
                e = exp_q.pop_front();
                chk("y", y, e.y);
                chk("co", 64'(co), 64'(e.co));
                chk("ovf", 64'(ovf), 64'(e.ovf));
            end
        end
        if (rst_n && in_valid && in_ready) exp_q.push_back(cur_exp);
    end

    task automatic drive(input int i);
        a   = tbl[i].a;
        b   = tbl[i].b;
        sub = tbl[i].sub;
        ci  = tbl[i].ci;
        sat = tbl[i].sat;
        cur_exp.y   = tbl[i].y;
        cur_exp.co  = tbl[i].co;
        cur_exp.ovf = tbl[i].ovf;
        in_valid = 1'b1;
    endtask

    // Called and returns at posedge+1.
    task automatic send_stream(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int t;
            t = 0;
            drive(i);
            @(negedge clk);
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                n_checks++;
                $display("FAIL accept_timeout: beat %0d not accepted in 20 cycles, required acceptance", i);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic run40(input string nm, input logic [39:0] va, input logic [39:0] vb,
                         input logic [39:0] ey, input logic eco, input logic eovf);
        int lat;
        lat = 0;
        a40 = va;
        b40 = vb;
        in_valid40 = 1'b1;
        while (lat < 10) begin
            @(posedge clk); lat++; #1 in_valid40 = 1'b0;
            @(negedge clk);
            if (out_valid40) break;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd3);
        chk({nm, "_y"}, 64'(y40), 64'(ey));
        chk({nm, "_co"}, 64'(co40), 64'(eco));
        chk({nm, "_ovf"}, 64'(ovf40), 64'(eovf));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        tbl[0]  = mk(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        tbl[1]  = mk(64'h0, 64'h1, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tbl[2]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        tbl[3]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1,
                     SAT_EN ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        tbl[4]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        tbl[5]  = mk(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tbl[6]  = mk(64'h5, 64'h3, 1'b1, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
        tbl[7]  = mk(64'h3, 64'h5, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        tbl[8]  = mk(64'h0000_0001_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0000_0002_0000_0000, 1'b0, 1'b0);
        tbl[9]  = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1,
                     SAT_EN ? 64'h8000_0000_0000_0000 : 64'h0, 1'b1, 1'b1);
        tbl[10] = mk(64'h5, 64'h3, 1'b1, 1'b0, 1'b0, 64'h1, 1'b1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; ci = 1'b0; sat = 1'b0; cur_exp = '0;
        in_valid40 = 1'b0; a40 = '0; b40 = '0;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", y, 64'd0);
        chk("rst_co", 64'(co), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid40", 64'(out_valid40), 64'd0);
        chk("rst_in_ready40", 64'(in_ready40), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of a single beat whose carry crosses the segment boundary.
        drive(0);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); lat++; #1 in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) break;
        end
        chk("latency_64", 64'(lat), 64'd2);
        @(posedge clk); #1;
        drain();

        // Whole table back-to-back at full throughput.
        send_stream(0, 10);
        drain();

        // Six beats with out_ready dropped for three cycles after the first result.
        fork
            send_stream(0, 5);
            begin : stall_ctl
                automatic int t = 0;
                @(negedge clk);
                while (!out_valid && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_y_held", y, tbl[1].y);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        drive(6);
        @(posedge clk); #1 drive(7);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_y", y, 64'd0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send_stream(8, 8);
        drain();

        // 40-bit build: three segments, last one 8 bits wide.
        run40("w40_wrap", 40'hFF_FFFF_FFFF, 40'h1, 40'h0, 1'b1, 1'b0);
        run40("w40_two_bounds", 40'h00_FFFF_FFFF, 40'h1, 40'h01_0000_0000, 1'b0, 1'b0);
        run40("w40_ovf", 40'h7F_FFFF_FFFF, 40'h1, 40'h80_0000_0000, 1'b0, 1'b1);

        chk("results_total", 64'(n_out), 64'd19);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
